kbd_scan4x4: RTL

Multiplexed 4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment driver. It drives one keypad column low at a time, samples the four row lines, and debounces whole-matrix frames. Key press and release events are delivered through a small FIFO with a valid/ack handshake, and a debounced 16-bit key bitmap is exported for a CPU input port (PORTI/PORTJ style). It runs on the board's slow peripheral clock (f1MHz) beside the display driver.

---
 rtl/kbd_scan4x4_pkg.sv | 13 +
 rtl/kbd_fifo.sv | 49 ++++
 rtl/kbd_scan4x4.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/kbd_scan4x4_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
package kbd_scan4x4_pkg;

    localparam int KEY_EVT_PRESS = 4;
    localparam int KEY_IDX_W     = 4;
    localparam int KEY_CODE_W    = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO for key events; a push on full is dropped unless a pop frees the slot.
module kbd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kbd_scan4x4.sv
// 4x4 keypad scanner: column drive, row sync, frame debounce and press/release event emitter.
// state   | meaning
// IDLE    | waiting for a debounced commit
// EMIT    | walking keys 0..15, pushing one event per changed key
module kbd_scan4x4 import kbd_scan4x4_pkg::*; #(
    parameter int SCAN_DIV   = 1000,
    parameter int DB_SCANS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [3:0]            col,
    input  logic [3:0]            row,
    output logic [15:0]           key_state,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_ack,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam int SW = (DB_SCANS > 1) ? $clog2(DB_SCANS) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DB_SCANS - 1);

    logic [3:0]            row_meta;
    logic [3:0]            row_sync;
    logic [DW-1:0]         div;
    logic [1:0]            ci;
    logic [15:0]           raw_acc;
    logic [15:0]           raw_next;
    logic [15:0]           prev;
    logic [SW-1:0]         stable_cnt;
    logic [SW-1:0]         stable_next;
    logic                  sample;
    logic                  frame_end;
    logic                  commit;

    emit_state_t           state;
    logic [KEY_IDX_W-1:0]  idx;
    logic [15:0]           diff;
    logic                  evt_push;
    logic [KEY_CODE_W-1:0] evt_code;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;

    assign col = ~(4'b0001 << ci);

    always_comb begin
        sample    = (div == DIV_LAST);
        frame_end = sample && (ci == 2'd3);
        raw_next  = raw_acc;
        for (int r = 0; r < 4; r++) begin
            raw_next[{2'(r), ci}] = ~row_sync[r];
        end
        if (raw_next == prev) begin
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end else begin
            stable_next = '0;
        end
        commit = frame_end && (stable_next == STABLE_MAX) && (raw_next != key_state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            div        <= '0;
            ci         <= '0;
            raw_acc    <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            key_state  <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                div     <= '0;
                ci      <= ci + 2'd1;
                raw_acc <= raw_next;
            end else begin
                div <= div + 1'b1;
            end
            if (frame_end) begin
                stable_cnt <= stable_next;
                if (raw_next != prev) begin
                    prev <= raw_next;
                end
                if (commit) begin
                    key_state <= raw_next;
                end
            end
        end
    end

    // key_state already holds the committed frame while EMIT runs, so it supplies the press bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            diff  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        diff  <= raw_next ^ key_state;
                        idx   <= '0;
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    idx <= idx + 1'b1;
                    if (idx == 4'd15) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        evt_push                    = (state == ST_EMIT) && diff[idx];
        evt_code                    = '0;
        evt_code[KEY_EVT_PRESS]     = key_state[idx];
        evt_code[KEY_IDX_W-1:0]     = idx;
    end

    assign fifo_pop  = key_ack && key_valid;
    assign key_valid = !fifo_empty;

    kbd_fifo #(
        .WIDTH (KEY_CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (evt_code),
        .pop       (fifo_pop),
        .head      (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (evt_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
